// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths, the writeback request record and a register one-hot helper.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wt;
        logic [DATA_W-1:0]     wd;
        logic [DATA_W-1:0]     pc;
    } wb_req_t;

    // One-hot over $1..$31; $0 maps to an all-zero mask.
    function automatic logic [NUM_REGS-1:1] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        return (NUM_REGS-1)'((NUM_REGS'(1) << r) >> 1);
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order FIFO holding MDU writeback requests until the GRF port is granted.
module wb_skid_fifo
    import mips_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       push_i,
    input  wb_req_t    push_data_i,
    input  logic       pop_i,
    output wb_req_t    head_o,
    output logic [1:0] count_o
);

    localparam int unsigned DEPTH = 2;

    wb_req_t    mem_q [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i && (count_q != 2'(DEPTH));
        pop_ok   = pop_i && (count_q != 2'd0);
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates pipeline and buffered MDU results onto the single GRF write port.
// Pending-write scoreboard is built only when GRF_WB_SCOREBOARD_EN is defined.
module grf_wb_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  p_valid,
    output logic                  p_ready,
    input  logic [REG_ADDR_W-1:0] p_wt,
    input  logic [DATA_W-1:0]     p_wd,
    input  logic [DATA_W-1:0]     p_pc,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_ADDR_W-1:0] m_wt,
    input  logic [DATA_W-1:0]     m_wd,
    input  logic [DATA_W-1:0]     m_pc,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_wt,
    input  logic [REG_ADDR_W-1:0] q_rs,
    input  logic [REG_ADDR_W-1:0] q_rt,
    input  logic [REG_ADDR_W-1:0] q_wt,
    output logic                  busy_rs,
    output logic                  busy_rt,
    output logic                  busy_wt,
    output logic                  Wr,
    output logic [REG_ADDR_W-1:0] Wt,
    output logic [DATA_W-1:0]     Wd,
    output logic [DATA_W-1:0]     Pc
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t           p_req, m_req, fifo_head, grant_req;
    logic [1:0]        fifo_count;
    logic              fifo_empty, force_drain;
    logic              p_grant, m_push, m_pop, any_grant;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wr_q, wr_d;
    logic              mdu_src_q, mdu_src_d;
    wb_req_t           out_q, out_d;

    always_comb begin
        p_req.wt = p_wt;
        p_req.wd = p_wd;
        p_req.pc = p_pc;
        m_req.wt = m_wt;
        m_req.wd = m_wd;
        m_req.pc = m_pc;
    end

    assign fifo_empty  = (fifo_count == 2'd0);
    assign force_drain = (wait_q == WAIT_W'(STARVE_LIMIT));
    assign m_ready     = (fifo_count < 2'd2);
    assign p_ready     = !force_drain || fifo_empty;
    assign m_push      = m_valid && m_ready;

    wb_skid_fifo u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .push_i      (m_push),
        .push_data_i (m_req),
        .pop_i       (m_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Pipeline wins unless the FIFO head has starved; writes to $0 are consumed silently.
    always_comb begin
        p_grant   = p_valid && p_ready;
        m_pop     = !p_grant && !fifo_empty;
        any_grant = p_grant || m_pop;
        grant_req = p_grant ? p_req : fifo_head;

        wait_d = wait_q;
        if (fifo_empty || m_pop) begin
            wait_d = '0;
        end else if (!force_drain) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        wr_d      = any_grant && (grant_req.wt != '0);
        mdu_src_d = m_pop;
        out_d     = out_q;
        if (any_grant) begin
            out_d = grant_req;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_q    <= '0;
            wr_q      <= 1'b0;
            mdu_src_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wait_q    <= wait_d;
            wr_q      <= wr_d;
            mdu_src_q <= mdu_src_d;
            out_q     <= out_d;
        end
    end

    assign Wr = wr_q;
    assign Wt = out_q.wt;
    assign Wd = out_q.wd;
    assign Pc = out_q.pc;

`ifdef GRF_WB_SCOREBOARD_EN
    logic [NUM_REGS-1:1] pend_q, pend_d;
    logic [NUM_REGS-1:1] set_mask, clr_mask;
    logic [NUM_REGS-1:0] pend_ext;

    // Clear lands once the GRF holds the MDU value; a same-cycle issue re-sets the bit.
    always_comb begin
        set_mask = issue_valid ? reg_onehot(issue_wt) : '0;
        clr_mask = (wr_q && mdu_src_q) ? reg_onehot(out_q.wt) : '0;
        pend_d   = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_ext = {pend_q, 1'b0};
    assign busy_rs  = pend_ext[q_rs];
    assign busy_rt  = pend_ext[q_rt];
    assign busy_wt  = pend_ext[q_wt];
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_wt, q_rs, q_rt, q_wt, mdu_src_q};
    assign busy_rs   = 1'b0;
    assign busy_rt   = 1'b0;
    assign busy_wt   = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter; busy expectations follow GRF_WB_SCOREBOARD_EN.
module tb_grf_wb_arbiter;

`ifdef GRF_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        Clk, Reset;
    logic        p_valid, p_ready, m_valid, m_ready;
    logic [4:0]  p_wt, m_wt, issue_wt, q_rs, q_rt, q_wt, Wt;
    logic [31:0] p_wd, p_pc, m_wd, m_pc, Wd, Pc;
    logic        issue_valid, busy_rs, busy_rt, busy_wt, Wr;

    int checks = 0;
    int errors = 0;

    grf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_wt(p_wt), .p_wd(p_wd), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_wt(m_wt), .m_wd(m_wd), .m_pc(m_pc),
        .issue_valid(issue_valid), .issue_wt(issue_wt),
        .q_rs(q_rs), .q_rt(q_rt), .q_wt(q_wt),
        .busy_rs(busy_rs), .busy_rt(busy_rt), .busy_wt(busy_wt),
        .Wr(Wr), .Wt(Wt), .Wd(Wd), .Pc(Pc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic idle_inputs;
        p_valid = 0; p_wt = 0; p_wd = 0; p_pc = 0;
        m_valid = 0; m_wt = 0; m_wd = 0; m_pc = 0;
        issue_valid = 0; issue_wt = 0;
    endtask

    task automatic test_reset;
        Reset = 1;
        tick; tick;
        checks++; if (Wr !== 1'b0 || Wt !== 5'd0 || Wd !== 32'd0 || Pc !== 32'd0) begin
            errors++; $display("FAIL reset_out: Wr=%0b Wt=%0d Wd=%0h Pc=%0h expected all 0", Wr, Wt, Wd, Pc); end
        checks++; if (busy_rs !== 1'b0 || busy_wt !== 1'b0) begin
            errors++; $display("FAIL reset_busy: busy_rs=%0b busy_wt=%0b expected 0", busy_rs, busy_wt); end
        Reset = 0;
        tick;
        checks++; if (p_ready !== 1'b1 || m_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: p_ready=%0b m_ready=%0b expected 1/1", p_ready, m_ready); end
    endtask

    task automatic test_pipe_write;
        p_valid = 1; p_wt = 5; p_wd = 32'h1234; p_pc = 32'h3000;
        tick;
        p_valid = 0;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd5 || Wd !== 32'h1234 || Pc !== 32'h3000) begin
            errors++; $display("FAIL pipe_wr: Wr=%0b Wt=%0d Wd=%0h Pc=%0h expected 1/5/1234/3000", Wr, Wt, Wd, Pc); end
        tick;
        checks++; if (Wr !== 1'b0) begin
            errors++; $display("FAIL pipe_idle: Wr=%0b expected 0", Wr); end
    endtask

    task automatic test_mdu_write;
        m_valid = 1; m_wt = 8; m_wd = 32'hAA; m_pc = 32'h100;
        tick;
        m_wt = 10; m_wd = 32'hBB; m_pc = 32'h104;
        checks++; if (Wr !== 1'b0 || m_ready !== 1'b1) begin
            errors++; $display("FAIL mdu_first: Wr=%0b m_ready=%0b expected 0/1", Wr, m_ready); end
        tick;
        m_valid = 0;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd8 || Wd !== 32'hAA || Pc !== 32'h100) begin
            errors++; $display("FAIL mdu_wr8: Wr=%0b Wt=%0d Wd=%0h Pc=%0h expected 1/8/aa/100", Wr, Wt, Wd, Pc); end
        checks++; if (m_ready !== 1'b1) begin
            errors++; $display("FAIL mdu_pushpop: m_ready=%0b expected 1", m_ready); end
        tick;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd10 || Wd !== 32'hBB) begin
            errors++; $display("FAIL mdu_wr10: Wr=%0b Wt=%0d Wd=%0h expected 1/10/bb", Wr, Wt, Wd); end
        tick;
        checks++; if (Wr !== 1'b0) begin
            errors++; $display("FAIL mdu_drained: Wr=%0b expected 0", Wr); end
    endtask

    task automatic test_wt_zero;
        p_valid = 1; p_wt = 0; p_wd = 32'hDEAD; p_pc = 32'h200;
        tick;
        p_valid = 0;
        checks++; if (Wr !== 1'b0) begin
            errors++; $display("FAIL wt_zero: Wr=%0b expected 0", Wr); end
    endtask

    task automatic test_starve;
        p_valid = 1; p_wt = 3; p_wd = 32'h33; p_pc = 32'h300;
        m_valid = 1; m_wt = 9; m_wd = 32'h99; m_pc = 32'h900;
        tick;
        m_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (p_ready !== 1'b1) begin
                errors++; $display("FAIL starve_wait%0d: p_ready=%0b expected 1", k, p_ready); end
            tick;
        end
        checks++; if (p_ready !== 1'b0 || Wr !== 1'b1 || Wt !== 5'd3) begin
            errors++; $display("FAIL starve_force: p_ready=%0b Wr=%0b Wt=%0d expected 0/1/3", p_ready, Wr, Wt); end
        tick;
        p_valid = 0;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd9 || Wd !== 32'h99 || Pc !== 32'h900) begin
            errors++; $display("FAIL starve_drain: Wr=%0b Wt=%0d Wd=%0h Pc=%0h expected 1/9/99/900", Wr, Wt, Wd, Pc); end
        checks++; if (p_ready !== 1'b1) begin
            errors++; $display("FAIL starve_release: p_ready=%0b expected 1", p_ready); end
        tick;
        checks++; if (Wr !== 1'b0) begin
            errors++; $display("FAIL starve_idle: Wr=%0b expected 0", Wr); end
    endtask

    task automatic test_fifo_full;
        p_valid = 1; p_wt = 4; p_wd = 32'h44; p_pc = 32'h400;
        m_valid = 1; m_wt = 20; m_wd = 32'h20;
        tick;
        m_wt = 21; m_wd = 32'h21;
        tick;
        m_wt = 22; m_wd = 32'h22;
        checks++; if (m_ready !== 1'b0) begin
            errors++; $display("FAIL full_mready: m_ready=%0b expected 0", m_ready); end
        tick; tick;
        checks++; if (m_ready !== 1'b0 || Wt !== 5'd4) begin
            errors++; $display("FAIL full_hold: m_ready=%0b Wt=%0d expected 0/4", m_ready, Wt); end
        tick;
        checks++; if (p_ready !== 1'b0 || m_ready !== 1'b0) begin
            errors++; $display("FAIL full_force: p_ready=%0b m_ready=%0b expected 0/0", p_ready, m_ready); end
        tick;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd20 || m_ready !== 1'b1 || p_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop20: Wr=%0b Wt=%0d m_ready=%0b p_ready=%0b expected 1/20/1/1", Wr, Wt, m_ready, p_ready); end
        tick;
        m_valid = 0; p_valid = 0;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd4) begin
            errors++; $display("FAIL full_pipe: Wr=%0b Wt=%0d expected 1/4", Wr, Wt); end
        tick;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd21 || Wd !== 32'h21) begin
            errors++; $display("FAIL full_pop21: Wr=%0b Wt=%0d Wd=%0h expected 1/21/21", Wr, Wt, Wd); end
        tick;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd22 || Wd !== 32'h22) begin
            errors++; $display("FAIL full_pop22: Wr=%0b Wt=%0d Wd=%0h expected 1/22/22", Wr, Wt, Wd); end
        tick;
        checks++; if (Wr !== 1'b0) begin
            errors++; $display("FAIL full_idle: Wr=%0b expected 0", Wr); end
    endtask

    task automatic test_scoreboard;
        q_rs = 12; q_rt = 0; q_wt = 12;
        issue_valid = 1; issue_wt = 12;
        #1;
        checks++; if (busy_rs !== 1'b0) begin
            errors++; $display("FAIL sb_before: busy_rs=%0b expected 0", busy_rs); end
        tick;
        issue_valid = 0;
        m_valid = 1; m_wt = 12; m_wd = 32'h5A;
        checks++; if (busy_rs !== SB_EN || busy_wt !== SB_EN || busy_rt !== 1'b0) begin
            errors++; $display("FAIL sb_set: rs=%0b wt=%0b rt=%0b expected %0b/%0b/0", busy_rs, busy_wt, busy_rt, SB_EN, SB_EN); end
        q_rs = 0;
        #1;
        checks++; if (busy_rs !== 1'b0) begin
            errors++; $display("FAIL sb_r0: busy_rs=%0b expected 0", busy_rs); end
        q_rs = 12;
        tick;
        m_valid = 0;
        checks++; if (busy_rs !== SB_EN) begin
            errors++; $display("FAIL sb_queued: busy_rs=%0b expected %0b", busy_rs, SB_EN); end
        tick;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd12 || busy_rs !== SB_EN) begin
            errors++; $display("FAIL sb_wr: Wr=%0b Wt=%0d busy_rs=%0b expected 1/12/%0b", Wr, Wt, busy_rs, SB_EN); end
        tick;
        checks++; if (busy_rs !== 1'b0) begin
            errors++; $display("FAIL sb_clear: busy_rs=%0b expected 0", busy_rs); end
        // Re-issue to 12 in the very cycle its clear is due: the bit must survive.
        issue_valid = 1; issue_wt = 12;
        tick;
        issue_valid = 0;
        m_valid = 1; m_wt = 12; m_wd = 32'h6B;
        tick;
        m_valid = 0;
        tick;
        issue_valid = 1; issue_wt = 12;
        checks++; if (Wr !== 1'b1 || Wt !== 5'd12) begin
            errors++; $display("FAIL sb_wr2: Wr=%0b Wt=%0d expected 1/12", Wr, Wt); end
        tick;
        issue_valid = 0;
        checks++; if (busy_rs !== SB_EN) begin
            errors++; $display("FAIL sb_setprio: busy_rs=%0b expected %0b", busy_rs, SB_EN); end
        m_valid = 1; m_wt = 12; m_wd = 32'h7C;
        tick;
        m_valid = 0;
        tick; tick;
        checks++; if (busy_rs !== 1'b0) begin
            errors++; $display("FAIL sb_clear2: busy_rs=%0b expected 0", busy_rs); end
    endtask

    task automatic test_reset_mid;
        q_rs = 12;
        issue_valid = 1; issue_wt = 12;
        p_valid = 1; p_wt = 0; p_wd = 32'h1;
        m_valid = 1; m_wt = 12; m_wd = 32'h77;
        tick;
        issue_valid = 0;
        m_wt = 13; m_wd = 32'h78;
        tick;
        checks++; if (m_ready !== 1'b0 || busy_rs !== SB_EN) begin
            errors++; $display("FAIL rst_full: m_ready=%0b busy_rs=%0b expected 0/%0b", m_ready, busy_rs, SB_EN); end
        Reset = 1; p_valid = 0; m_valid = 0;
        tick;
        checks++; if (Wr !== 1'b0 || busy_rs !== 1'b0 || m_ready !== 1'b1 || p_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid: Wr=%0b busy_rs=%0b m_ready=%0b p_ready=%0b expected 0/0/1/1", Wr, busy_rs, m_ready, p_ready); end
        checks++; if (Wt !== 5'd0 || Wd !== 32'd0 || Pc !== 32'd0) begin
            errors++; $display("FAIL rst_mid_out: Wt=%0d Wd=%0h Pc=%0h expected 0", Wt, Wd, Pc); end
        Reset = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (Wr !== 1'b0) begin
                errors++; $display("FAIL rst_stale%0d: Wr=%0b expected 0", k, Wr); end
        end
    endtask

    initial begin
        Reset = 1;
        q_rs = 0; q_rt = 0; q_wt = 0;
        idle_inputs();
        test_reset();
        test_pipe_write();
        test_mdu_write();
        test_wt_zero();
        test_starve();
        test_fifo_full();
        test_scoreboard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
